// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: card/keypad front end that builds acc_num/pin for the authenticator and enforces retry lockout.
// Optional COLLECT idle timeout is compiled in when ENTRY_TIMEOUT_EN is defined.
module pin_entry_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_inserted,
    input  logic [3:0]  card_acc_num,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        acc_found_stat,
    input  logic        acc_auth_stat,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [2:0]  digit_count,
    output logic [1:0]  tries_left,
    output logic        auth_valid,
    output logic        auth_ok,
    output logic        card_locked,
    output logic        timed_out,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANTED = 3'd3,
        S_REJECT  = 3'd4,
        S_LOCKED  = 3'd5
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    if (MAX_TRIES < 1 || MAX_TRIES > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pin_entry_ctrl: MAX_TRIES must be 1..3 and TIMEOUT_CYCLES >= 1");
    end

    state_t      r_state, w_state;
    logic [3:0]  r_acc_num, w_acc_num;
    logic [15:0] r_pin, w_pin;
    logic [2:0]  r_digit_count, w_digit_count;
    logic [1:0]  r_tries_left, w_tries_left;
    logic        r_auth_valid, w_auth_valid;
    logic        r_auth_ok, w_auth_ok;
    logic        r_card_locked, w_card_locked;
    logic        w_clear_all;
    logic        w_is_digit;
    logic        w_to_set;

    assign w_is_digit = (key_code <= 4'd9);

`ifdef ENTRY_TIMEOUT_EN
    localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer, w_timer;
    logic          r_timed_out, w_timed_out;

    // Timer is zero outside COLLECT, so entering COLLECT always starts a fresh count.
    assign w_timer  = (r_state == S_COLLECT && !key_valid) ? r_timer + TW'(1) : '0;
    assign w_to_set = (r_state == S_COLLECT) && card_inserted && !key_valid && (r_timer == TLAST);

    always_comb begin
        w_timed_out = r_timed_out | w_to_set;
        if (w_clear_all) begin
            w_timed_out = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_timer     <= w_timer;
            r_timed_out <= w_timed_out;
        end
    end

    assign timed_out = r_timed_out;
`else
    assign w_to_set  = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        w_state       = r_state;
        w_acc_num     = r_acc_num;
        w_pin         = r_pin;
        w_digit_count = r_digit_count;
        w_tries_left  = r_tries_left;
        w_auth_valid  = 1'b0;
        w_auth_ok     = r_auth_ok;
        w_card_locked = r_card_locked;
        w_clear_all   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (card_inserted) begin
                    w_acc_num     = card_acc_num;
                    w_tries_left  = 2'(MAX_TRIES);
                    w_pin         = '0;
                    w_digit_count = '0;
                    w_state       = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Card removal outranks any key strobe in the same cycle.
                if (!card_inserted) begin
                    w_clear_all = 1'b1;
                end else if (key_valid) begin
                    if (w_is_digit) begin
                        if (r_digit_count < 3'd4) begin
                            w_pin         = {r_pin[11:0], key_code};
                            w_digit_count = r_digit_count + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_pin         = '0;
                        w_digit_count = '0;
                    end else if (key_code == KEY_ENTER && r_digit_count == 3'd4) begin
                        w_state = S_CHECK;
                    end
                end else if (w_to_set) begin
                    w_state = S_REJECT;
                end
            end
            S_CHECK: begin
                if (!card_inserted) begin
                    w_clear_all = 1'b1;
                end else begin
                    w_auth_valid = 1'b1;
                    if (acc_found_stat && acc_auth_stat) begin
                        w_state   = S_GRANTED;
                        w_auth_ok = 1'b1;
                    end else if (!acc_found_stat) begin
                        w_state = S_REJECT;
                    end else begin
                        w_tries_left = r_tries_left - 2'd1;
                        if (r_tries_left == 2'd1) begin
                            w_state       = S_LOCKED;
                            w_card_locked = 1'b1;
                        end else begin
                            w_state       = S_COLLECT;
                            w_pin         = '0;
                            w_digit_count = '0;
                        end
                    end
                end
            end
            S_GRANTED, S_REJECT: begin
                if (!card_inserted) begin
                    w_clear_all = 1'b1;
                end
            end
            S_LOCKED: begin
                // Card is retained: only rst leaves this state.
            end
            default: begin
                w_clear_all = 1'b1;
            end
        endcase

        if (w_clear_all) begin
            w_state       = S_IDLE;
            w_acc_num     = '0;
            w_pin         = '0;
            w_digit_count = '0;
            w_tries_left  = '0;
            w_auth_ok     = 1'b0;
            w_card_locked = 1'b0;
        end
    end

    // NOTE: async reset clears every register; all state here is control, none is memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc_num     <= '0;
            r_pin         <= '0;
            r_digit_count <= '0;
            r_tries_left  <= '0;
            r_auth_valid  <= 1'b0;
            r_auth_ok     <= 1'b0;
            r_card_locked <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state       <= w_state;
            r_acc_num     <= w_acc_num;
            r_pin         <= w_pin;
            r_digit_count <= w_digit_count;
            r_tries_left  <= w_tries_left;
            r_auth_valid  <= w_auth_valid;
            r_auth_ok     <= w_auth_ok;
            r_card_locked <= w_card_locked;
        end
    end

    assign state       = r_state;
    assign acc_num     = r_acc_num;
    assign pin         = r_pin;
    assign digit_count = r_digit_count;
    assign tries_left  = r_tries_left;
    assign auth_valid  = r_auth_valid;
    assign auth_ok     = r_auth_ok;
    assign card_locked = r_card_locked;

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
- Front-end controller that produces the account number and PIN consumed by the ATM authenticator, then sequences the authentication attempt.
- Latches the card's account number, assembles a 4-digit BCD PIN from keypad strobes, and presents acc_num/pin for one check cycle.
- Samples the authenticator's found/auth status and enforces a retry limit with card lockout.
- Sits between the keypad/card-reader inputs and the authenticator. Its grant result gates the transaction FSM.

Parameters:
- MAX_TRIES, 3: failed PIN attempts allowed before lockout (1..3).
- TIMEOUT_CYCLES, 1000: idle cycles allowed in COLLECT before abort; used only with ENTRY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- card_inserted  in  1  level; high while a card is in the slot.
- card_acc_num  in  4  account number read from the card; valid while card_inserted=1.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  4  0-9 = digit; 4'hA = CLEAR; 4'hB = ENTER; all other codes are ignored.
- acc_found_stat  in  1  from authenticator; 1 = account found.
- acc_auth_stat  in  1  from authenticator; 1 = PIN authenticated.
- acc_num  out  4  account number driven to the authenticator.
- pin  out  16  assembled PIN; first digit in [15:12].
- digit_count  out  3  digits entered, 0..4.
- tries_left  out  2  remaining attempts.
- auth_valid  out  1  one-cycle pulse when an attempt result is decided.
- auth_ok  out  1  level; 1 in GRANTED only.
- card_locked  out  1  level; card retained.
- timed_out  out  1  level; entry abandoned by timeout.
- state  out  3  IDLE=0, COLLECT=1, CHECK=2, GRANTED=3, REJECT=4, LOCKED=5.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including acc_num, pin, digit_count, tries_left, auth_valid, auth_ok, card_locked and timed_out.
- IDLE: if card_inserted=1, latch acc_num<=card_acc_num, tries_left<=MAX_TRIES, pin<=0, digit_count<=0, then go to COLLECT.
- COLLECT, digit key with digit_count<4: pin<={pin[11:0],key_code}; digit_count+1.
- COLLECT, digit key with digit_count==4: ignored.
- COLLECT, CLEAR: pin<=0, digit_count<=0.
- COLLECT, ENTER with digit_count==4: go to CHECK. ENTER with fewer than 4 digits is ignored.
- COLLECT, undefined codes: ignored.
- CHECK lasts exactly one cycle. acc_num and pin are held stable. The authenticator is combinational, so acc_found_stat and acc_auth_stat are sampled on the clock edge leaving CHECK. Every exit from CHECK asserts auth_valid for one cycle.
- CHECK, found=1 and auth=1: go to GRANTED; auth_ok=1.
- CHECK, found=0: go to REJECT; tries_left unchanged.
- CHECK, found=1 and auth=0: tries_left-1. If the new value is 0, go to LOCKED with card_locked=1. Otherwise return to COLLECT with pin=0 and digit_count=0.
- GRANTED and REJECT: hold all outputs until card_inserted=0, then go to IDLE and clear all outputs.
- LOCKED: card removal is ignored. card_locked and state persist until rst.
- card_inserted=0 in COLLECT or CHECK aborts to IDLE with all outputs cleared and no auth_valid pulse. Removal has priority over a key strobe in the same cycle.
- key_valid outside COLLECT is ignored.
- Latency from ENTER strobe to auth_valid: 2 cycles (COLLECT->CHECK, CHECK->result).

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- When defined: a counter is cleared on entry to COLLECT and on every key_valid in COLLECT, and increments on other COLLECT cycles. When it reaches TIMEOUT_CYCLES-1, go to REJECT with timed_out=1. timed_out clears on the return to IDLE.
- When undefined: no counter is built, timed_out is tied to 0, and COLLECT waits indefinitely.

Test Plan:
- Grant path: card acc 4'd3; keys 1,2,3,4, ENTER; bench drives found=1, auth=1 -> pin=16'h1234. auth_valid pulses 2 cycles after ENTER with auth_ok=1 and state=3. Card removal -> state=0, all outputs 0.
- Entry editing: keys 5,6, CLEAR, 7,8,9,0,1 (fifth digit), ENTER -> pin=16'h7890, digit_count=4. The fifth digit is ignored. ENTER after only 3 digits causes no state change.
- Lockout: 3 attempts with auth=0 -> tries_left steps 3->2->1->0 and auth_valid pulses each time. After the third attempt state=5, card_locked=1. card_inserted=0 leaves state=5; rst clears it.
- Unknown account: found=0 on check -> state=4, auth_ok=0, tries_left=3.
- Abort: card removed after 2 digits, in the same cycle as a digit strobe -> state=0, pin=0, no auth_valid pulse.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=8: one digit then 8 idle cycles -> state=4, timed_out=1. A key strobe at idle cycle 6 restarts the count.
